alarm_trigger_unit: RTL and testbench

- Alarm sequencer for the alarm clock. Compares the running time against the stored alarm time and handles the stop and snooze keys.
- Produces ALARM_ENABLE and ALARM_DOING, which directly drive the piezo melody stage downstream.
- Sits between the timekeeping/alarm-setting logic and the piezo driver.
- Derives its own 1 s tick from the system clock.

---
 rtl/alarm_trigger_unit.sv | 130 +++++++++++++
 tb/tb_alarm_trigger_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_trigger_unit.sv
// Alarm sequencer: rings on an alarm-time match, handles stop/snooze keys, auto-stops and re-rings from its own 1 s tick.
// Latency: all outputs registered, visible one cycle after the causing input; no backpressure (keys are levels, edge-detected here).
module alarm_trigger_unit #(
  parameter int TICK_DIV   = 1000,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [4:0] CUR_HOUR,
  input  logic [5:0] CUR_MIN,
  input  logic [5:0] CUR_SEC,
  input  logic [4:0] AL_HOUR,
  input  logic [5:0] AL_MIN,
  input  logic       AL_ON,
  input  logic       KEY_STOP,
  input  logic       KEY_SNOOZE,
  output logic       ALARM_ENABLE,
  output logic       ALARM_DOING,
  output logic       SNOOZE_ACTIVE,
  output logic [1:0] STATE
);

  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SEC_W   = (SEC_MAX > 1) ? $clog2(SEC_MAX) : 1;
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  RING_LAST   = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0]  SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_match_d;
  logic              r_stop_d;
  logic              r_snooze_d;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [SEC_W-1:0]  r_sec_cnt;
  logic              r_alarm_enable;
  logic              r_alarm_doing;
  logic              r_snooze_active;

  logic w_match;
  logic w_trigger;
  logic w_stop_p;
  logic w_snooze_p;
  logic w_tick;
  logic w_cnt_clr;

  assign w_match    = AL_ON && (CUR_HOUR == AL_HOUR) && (CUR_MIN == AL_MIN) && (CUR_SEC == 6'd0);
  assign w_trigger  = w_match && !r_match_d;
  assign w_stop_p   = KEY_STOP && !r_stop_d;
  assign w_snooze_p = KEY_SNOOZE && !r_snooze_d;
  assign w_tick     = (r_tick_cnt == TICK_LAST);

  // Restart the second count whenever a timed state is (re)entered, so each ring/snooze interval is exact.
  assign w_cnt_clr  = ((w_next == ST_RINGING) || (w_next == ST_SNOOZE)) && (w_next != r_state);

  always_comb begin
    w_next = r_state;
    if (!AL_ON) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trigger) w_next = ST_RINGING;
        end
        ST_RINGING: begin
          if (w_stop_p)                              w_next = ST_DONE;
          else if (w_snooze_p)                       w_next = ST_SNOOZE;
          else if (w_tick && (r_sec_cnt == RING_LAST)) w_next = ST_DONE;
        end
        ST_SNOOZE: begin
          if (w_stop_p)                                  w_next = ST_DONE;
          else if (w_tick && (r_sec_cnt == SNOOZE_LAST)) w_next = ST_RINGING;
        end
        ST_DONE: begin
          // Hold off until the alarm minute has passed so the same minute cannot ring twice.
          if (CUR_MIN != AL_MIN) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state         <= ST_IDLE;
      r_match_d       <= 1'b0;
      r_stop_d        <= 1'b0;
      r_snooze_d      <= 1'b0;
      r_tick_cnt      <= '0;
      r_sec_cnt       <= '0;
      r_alarm_enable  <= 1'b0;
      r_alarm_doing   <= 1'b0;
      r_snooze_active <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_match_d       <= w_match;
      r_stop_d        <= KEY_STOP;
      r_snooze_d      <= KEY_SNOOZE;
      r_alarm_enable  <= AL_ON;
      r_alarm_doing   <= (w_next == ST_RINGING);
      r_snooze_active <= (w_next == ST_SNOOZE);

      if (w_cnt_clr) begin
        r_tick_cnt <= '0;
        r_sec_cnt  <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= '0;
        r_sec_cnt  <= r_sec_cnt + SEC_W'(1);
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      end
    end
  end

  assign ALARM_ENABLE  = r_alarm_enable;
  assign ALARM_DOING   = r_alarm_doing;
  assign SNOOZE_ACTIVE = r_snooze_active;
  assign STATE         = r_state;

endmodule

// File: tb/tb_alarm_trigger_unit.sv
// Bench for alarm_trigger_unit with TICK_DIV=4, RING_SEC=3, SNOOZE_SEC=2; alarm fixed at 07:30.
module tb_alarm_trigger_unit;

  logic       CLK = 1'b0;
  logic       RESETN;
  logic [4:0] CUR_HOUR;
  logic [5:0] CUR_MIN;
  logic [5:0] CUR_SEC;
  logic [4:0] AL_HOUR;
  logic [5:0] AL_MIN;
  logic       AL_ON;
  logic       KEY_STOP;
  logic       KEY_SNOOZE;
  logic       ALARM_ENABLE;
  logic       ALARM_DOING;
  logic       SNOOZE_ACTIVE;
  logic [1:0] STATE;

  alarm_trigger_unit #(
    .TICK_DIV   (4),
    .RING_SEC   (3),
    .SNOOZE_SEC (2)
  ) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .CUR_HOUR      (CUR_HOUR),
    .CUR_MIN       (CUR_MIN),
    .CUR_SEC       (CUR_SEC),
    .AL_HOUR       (AL_HOUR),
    .AL_MIN        (AL_MIN),
    .AL_ON         (AL_ON),
    .KEY_STOP      (KEY_STOP),
    .KEY_SNOOZE    (KEY_SNOOZE),
    .ALARM_ENABLE  (ALARM_ENABLE),
    .ALARM_DOING   (ALARM_DOING),
    .SNOOZE_ACTIVE (SNOOZE_ACTIVE),
    .STATE         (STATE)
  );

  always #5 CLK = ~CLK;

  // Expected output word: {ALARM_ENABLE, ALARM_DOING, SNOOZE_ACTIVE, STATE[1:0]}
  localparam logic [4:0] E_ZERO = 5'b0_0_0_00;
  localparam logic [4:0] E_IDLE = 5'b1_0_0_00;
  localparam logic [4:0] E_RING = 5'b1_1_0_01;
  localparam logic [4:0] E_SNZ  = 5'b1_0_1_10;
  localparam logic [4:0] E_DONE = 5'b1_0_0_11;

  typedef struct {
    logic       rstn;
    logic       on;
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic       stop;
    logic       snz;
    logic [4:0] exp;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] exp_q[$];
  string      tag_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic vec_t mk(input logic rstn, input logic on, input logic [4:0] hr,
                              input logic [5:0] mn, input logic [5:0] sc,
                              input logic stop, input logic snz, input logic [4:0] exp);
    vec_t v;
    v.rstn = rstn; v.on = on; v.hr = hr; v.mn = mn; v.sc = sc;
    v.stop = stop; v.snz = snz; v.exp = exp;
    return v;
  endfunction

  task automatic check_out();
    logic [4:0] e;
    logic [4:0] got;
    string      t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: output sampled with no expected entry queued");
    end else begin
      e   = exp_q.pop_front();
      t   = tag_q.pop_front();
      got = {ALARM_ENABLE, ALARM_DOING, SNOOZE_ACTIVE, STATE};
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got en/doing/snz/state=%b/%b/%b/%0d, expected %b/%b/%b/%0d (t=%0t)",
                 t, got[4], got[3], got[2], got[1:0], e[4], e[3], e[2], e[1:0], $time);
      end
    end
  endtask

  task automatic step(input logic rstn, input logic on, input logic [4:0] hr,
                      input logic [5:0] mn, input logic [5:0] sc,
                      input logic stop, input logic snz, input logic [4:0] exp, input string tag);
    @(negedge CLK);
    RESETN     = rstn;
    AL_ON      = on;
    CUR_HOUR   = hr;
    CUR_MIN    = mn;
    CUR_SEC    = sc;
    KEY_STOP   = stop;
    KEY_SNOOZE = snz;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  // Armed, out of reset, hour fixed at 07.
  task automatic cyc(input logic on, input logic [5:0] mn, input logic [5:0] sc,
                     input logic stop, input logic snz, input logic [4:0] exp, input string tag);
    step(1'b1, on, 5'd7, mn, sc, stop, snz, exp, tag);
  endtask

  initial begin
    AL_HOUR    = 5'd7;
    AL_MIN     = 6'd30;
    RESETN     = 1'b0;
    AL_ON      = 1'b0;
    CUR_HOUR   = 5'd7;
    CUR_MIN    = 6'd29;
    CUR_SEC    = 6'd59;
    KEY_STOP   = 1'b0;
    KEY_SNOOZE = 1'b0;

    // Trigger, full 12-cycle ring, auto-stop, no re-ring within the alarm minute.
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, E_ZERO));
    tbl.push_back(mk(0, 1, 7, 29, 59, 0, 0, E_ZERO));
    tbl.push_back(mk(1, 1, 7, 29, 59, 0, 0, E_IDLE));
    tbl.push_back(mk(1, 1, 8, 30,  0, 0, 0, E_IDLE));
    tbl.push_back(mk(1, 1, 7, 29, 59, 0, 0, E_IDLE));
    tbl.push_back(mk(1, 1, 7, 30,  0, 0, 0, E_RING));
    for (int i = 0; i < 11; i++) tbl.push_back(mk(1, 1, 7, 30, 1, 0, 0, E_RING));
    tbl.push_back(mk(1, 1, 7, 30,  1, 0, 0, E_DONE));
    tbl.push_back(mk(1, 1, 7, 30,  2, 0, 0, E_DONE));
    tbl.push_back(mk(1, 1, 7, 30,  0, 0, 0, E_DONE));
    tbl.push_back(mk(1, 1, 7, 31,  0, 0, 0, E_IDLE));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].rstn, tbl[i].on, tbl[i].hr, tbl[i].mn, tbl[i].sc,
           tbl[i].stop, tbl[i].snz, tbl[i].exp, $sformatf("table[%0d]", i));

    // Stop key while ringing, held stop, then minute rollover re-arms.
    cyc(1, 30, 0, 0, 0, E_RING, "stop_trigger");
    cyc(1, 30, 1, 1, 0, E_DONE, "stop_press");
    cyc(1, 30, 2, 1, 0, E_DONE, "stop_held");
    cyc(1, 30, 3, 0, 0, E_DONE, "done_same_minute");
    cyc(1, 31, 0, 0, 0, E_IDLE, "done_to_idle");

    // Snooze held for 20 cycles: one snooze of 8 cycles, one re-ring, then ring timeout.
    cyc(1, 30, 0, 0, 0, E_RING, "snz_trigger");
    cyc(1, 30, 1, 0, 0, E_RING, "snz_ring");
    cyc(1, 30, 1, 0, 1, E_SNZ,  "snz_enter");
    for (int i = 0; i < 7; i++) cyc(1, 30, 1, 0, 1, E_SNZ, $sformatf("snz_wait[%0d]", i));
    cyc(1, 30, 1, 0, 1, E_RING, "snz_rering");
    for (int i = 0; i < 11; i++) cyc(1, 30, 1, 0, 1, E_RING, $sformatf("snz_held_ring[%0d]", i));
    cyc(1, 30, 1, 0, 0, E_DONE, "rering_timeout");
    cyc(1, 31, 0, 0, 0, E_IDLE, "snz_to_idle");

    // Stop and snooze rising together: stop wins.
    cyc(1, 30, 0, 0, 0, E_RING, "prio_trigger");
    cyc(1, 30, 1, 1, 1, E_DONE, "prio_stop_wins");
    cyc(1, 30, 2, 0, 0, E_DONE, "prio_done_hold");
    cyc(1, 31, 0, 0, 0, E_IDLE, "prio_to_idle");

    // Stop during snooze.
    cyc(1, 30, 0, 0, 0, E_RING, "snzstop_trigger");
    cyc(1, 30, 1, 0, 1, E_SNZ,  "snzstop_snooze");
    cyc(1, 30, 1, 0, 0, E_SNZ,  "snzstop_release");
    cyc(1, 30, 1, 0, 1, E_SNZ,  "snzstop_snooze_ignored");
    cyc(1, 30, 1, 1, 0, E_DONE, "snzstop_stop");
    cyc(1, 31, 0, 0, 0, E_IDLE, "snzstop_to_idle");

    // Disarm during snooze, match while disarmed, then arming inside the alarm second.
    cyc(1, 30, 0, 0, 0, E_RING, "disarm_trigger");
    cyc(1, 30, 1, 0, 1, E_SNZ,  "disarm_snooze");
    cyc(1, 30, 1, 0, 0, E_SNZ,  "disarm_snooze_hold");
    cyc(0, 30, 1, 0, 0, E_ZERO, "disarm_in_snooze");
    cyc(0, 31, 0, 0, 0, E_ZERO, "disarmed_idle");
    cyc(0, 30, 0, 0, 0, E_ZERO, "disarmed_match");
    cyc(0, 30, 0, 0, 0, E_ZERO, "disarmed_match_hold");
    cyc(1, 30, 0, 0, 0, E_RING, "arm_in_alarm_second");
    cyc(1, 30, 0, 0, 0, E_RING, "ring_match_held");

    // Reset mid-ring with match still true: cleared that edge, re-triggers right after release.
    step(0, 1, 7, 30, 0, 0, 0, E_ZERO, "reset_mid_ring");
    step(1, 1, 7, 30, 0, 0, 0, E_RING, "retrigger_after_reset");
    cyc(1, 30, 0, 0, 0, E_RING, "ring_after_reset");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
